// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } btn_state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw pins in, debounced level and press/release pulses out.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (input btn_raw, output btn_level, btn_press, btn_release);
  modport slave  (input btn_level, btn_press, btn_release);
endinterface

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and counter.
// BUTTON_AUTOREPEAT_EN adds hold/auto-repeat press pulses while held.
//
// state        | meaning
// IDLE         | stable released
// WAIT_PRESS   | synced input high, counting toward accepted press
// PRESSED      | stable pressed
// WAIT_RELEASE | synced input low, counting toward accepted release
module btn_debounce_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES        = 4,
  parameter bit INPUT_ACTIVE_LOW = 1'b1
`ifdef BUTTON_AUTOREPEAT_EN
  ,
  parameter int HOLD_CYCLES      = 20,
  parameter int REPEAT_CYCLES    = 10
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_a, sync_s;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a      <= 1'b0;
      sync_s      <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync_a      <= raw ^ INPUT_ACTIVE_LOW;
      sync_s      <= sync_a;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              repeating, repeating_nxt;
  logic              hold_fire;

  assign hold_fire = (state == PRESSED) && sync_s &&
                     (hold_cnt == (repeating ? HOLD_W'(REPEAT_CYCLES - 1)
                                             : HOLD_W'(HOLD_CYCLES - 1)));

  // Hold count freezes during a release bounce and only clears on an accepted release.
  always_comb begin
    hold_cnt_nxt  = hold_cnt;
    repeating_nxt = repeating;
    if (state_nxt == IDLE) begin
      hold_cnt_nxt  = '0;
      repeating_nxt = 1'b0;
    end else if (hold_fire) begin
      hold_cnt_nxt  = '0;
      repeating_nxt = 1'b1;
    end else if ((state == PRESSED) && sync_s) begin
      hold_cnt_nxt = hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_nxt;
      repeating <= repeating_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sync_s) begin
          state_nxt = WAIT_PRESS;
          cnt_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_s) begin
          state_nxt = WAIT_RELEASE;
          cnt_nxt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (sync_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
`ifdef BUTTON_AUTOREPEAT_EN
    if (hold_fire) press_nxt = 1'b1;
`endif
  end

endmodule

// File: rtl/button_conditioner.sv
// N independent debounced button channels with press/release pulses.
// BUTTON_AUTOREPEAT_EN enables hold-to-repeat press pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN            = 4,
  parameter int CLK_HZ           = 50_000_000,
  parameter int DEBOUNCE_MS      = 10,
  parameter bit INPUT_ACTIVE_LOW = 1'b1,
  parameter int HOLD_MS          = 500,
  parameter int REPEAT_MS        = 100
) (
  input logic                  clk,
  input logic                  reset,
  button_conditioner_if.master bus
);

  localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam int HOLD_CYCLES   = ms_to_cycles(CLK_HZ, HOLD_MS);
  localparam int REPEAT_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_MS);
`endif

  logic [N_BTN-1:0] level_w, press_w, release_w;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_channel #(
      .DB_CYCLES        (DB_CYCLES),
      .INPUT_ACTIVE_LOW (INPUT_ACTIVE_LOW)
`ifdef BUTTON_AUTOREPEAT_EN
      ,
      .HOLD_CYCLES      (HOLD_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .raw         (bus.btn_raw[i]),
      .btn_level   (level_w[i]),
      .btn_press   (press_w[i]),
      .btn_release (release_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;

endmodule
